muldiv_control: RTL and testbench

MULDIV_CONTROL -- requirements
Module: muldiv_control

---
 rtl/muldiv_control.sv | 248 ++++++++++++++++++++++++
 tb/tb_muldiv_control.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_control.sv
// muldiv_control: HI/LO multiply/divide unit for a MIPS-style pipeline.
//
// Multiplies and divides run iteratively, one radix-2 step per clock, for
// exactly WIDTH cycles. Operands are reduced to magnitudes when the operation
// is launched. The signs of the results are applied when HI/LO are committed.
// MTHI/MTLO write HI/LO directly when they are accepted and never start an
// iteration.
//
// Handshake: start is sampled on a rising edge only while the unit is idle,
// flush is low and the first post-reset cycle has passed. Callers stall on
// busy and do not rely on start being held. done is a one-cycle pulse that
// follows the commit edge. A new start may be presented in the cycle where
// done is high.
//
// Ports:
//   clk         - clock, rising edge
//   rst_n       - asynchronous active-low reset
//   start       - operation request, qualified by Funct
//   Funct       - MULT/MULTU/DIV/DIVU/MTHI/MTLO; other codes are no-ops
//   a, b        - rs / rt operands
//   flush       - abort the in-flight operation; blocks acceptance of start
//   busy        - an iterative operation is in progress
//   done        - one-cycle pulse after a MULT/DIV commit
//   hi, lo      - architectural HI / LO registers
//   dbg_state_o - current FSM state (0 = IDLE, 1 = RUN)
module muldiv_control #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       Funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [0:0]       dbg_state_o
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // Architectural and control state
  logic [0:0]       state_q, state_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
  logic [WIDTH-1:0] hi_q,    hi_d;
  logic [WIDTH-1:0] lo_q,    lo_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  // Low for the first cycle after reset release, so that no request is taken
  // on the first edge.
  logic             ready_q, ready_d;

  // Iteration datapath.
  //   multiply: acc = running high half, mq = multiplier shifting out and
  //             product low half shifting in, opnd = multiplicand
  //   divide:   acc = partial remainder, mq = dividend shifting out and
  //             quotient shifting in, opnd = divisor
  logic [WIDTH-1:0] acc_q,     acc_d;
  logic [WIDTH-1:0] mq_q,      mq_d;
  logic [WIDTH-1:0] opnd_q,    opnd_d;
  logic             is_div_q,  is_div_d;
  logic             neg_res_q, neg_res_d;  // product / quotient is negative
  logic             neg_rem_q, neg_rem_d;  // remainder takes the dividend sign
  logic             div0_q,    div0_d;

  // Request decode
  logic is_mul_f, is_div_f, is_signed_f, accept, launch;

  assign is_mul_f    = (Funct == F_MULT) || (Funct == F_MULTU);
  assign is_div_f    = (Funct == F_DIV)  || (Funct == F_DIVU);
  assign is_signed_f = (Funct == F_MULT) || (Funct == F_DIV);
  assign accept      = start && !flush && ready_q && (state_q == S_IDLE);
  assign launch      = accept && (is_mul_f || is_div_f);

  // Operand magnitudes. -2^(WIDTH-1) maps onto itself, and read as unsigned
  // that is the correct magnitude.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign a_neg = is_signed_f && a[WIDTH-1];
  assign b_neg = is_signed_f && b[WIDTH-1];
  assign mag_a = a_neg ? -a : a;
  assign mag_b = b_neg ? -b : b;

  // One radix-2 step
  logic [WIDTH:0]   sum_m;     // shift-add partial sum with its carry
  logic [WIDTH:0]   shl;       // partial remainder shifted left by one
  logic [WIDTH-1:0] diff;      // trial subtraction, valid when fits is set
  logic             fits;
  logic [WIDTH-1:0] acc_step;
  logic [WIDTH-1:0] mq_step;

  assign sum_m = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opnd_q} : '0);
  assign shl   = {acc_q, mq_q[WIDTH-1]};
  assign fits  = (shl >= {1'b0, opnd_q});
  // When the divisor fits, the true difference is below the divisor, so
  // WIDTH bits hold it exactly.
  assign diff  = shl[WIDTH-1:0] - opnd_q;

  always_comb begin
    acc_step = acc_q;
    mq_step  = mq_q;
    if (is_div_q) begin
      acc_step = fits ? diff : shl[WIDTH-1:0];
      mq_step  = {mq_q[WIDTH-2:0], fits};
    end else begin
      acc_step = sum_m[WIDTH:1];
      mq_step  = {sum_m[0], mq_q[WIDTH-1:1]};
    end
  end

  // Commit values, taken from the result of the final step.
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [WIDTH-1:0]   commit_hi, commit_lo;

  assign prod     = {acc_step, mq_step};
  assign prod_fix = neg_res_q ? -prod : prod;
  // Divide by zero leaves quotient bits all ones and remainder = |a|. The
  // dividend sign then restores hi = a, and lo is forced to all ones.
  assign quo_fix  = div0_q ? '1 : (neg_res_q ? -mq_step : mq_step);
  assign rem_fix  = neg_rem_q ? -acc_step : acc_step;

  assign commit_hi = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
  assign commit_lo = is_div_q ? quo_fix : prod_fix[WIDTH-1:0];

  // Next state
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    ready_d   = 1'b1;
    acc_d     = acc_q;
    mq_d      = mq_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (Funct == F_MTHI) begin
            hi_d = a;
          end else if (Funct == F_MTLO) begin
            lo_d = a;
          end else if (launch) begin
            state_d   = S_RUN;
            busy_d    = 1'b1;
            cnt_d     = '0;
            acc_d     = '0;
            mq_d      = mag_a;
            opnd_d    = mag_b;
            is_div_d  = is_div_f;
            neg_res_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            div0_d    = is_div_f && (b == '0);
          end
        end
      end

      S_RUN: begin
        if (flush) begin
          // Abort: HI/LO keep their values and no done pulse is produced.
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          acc_d = acc_step;
          mq_d  = mq_step;
          if (cnt_q == CNT_LAST) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            hi_d    = commit_hi;
            lo_d    = commit_lo;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      acc_q     <= '0;
      mq_q      <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      acc_q     <= acc_d;
      mq_q      <= mq_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_muldiv_control.sv
// Bench for muldiv_control at WIDTH=32. Inputs are driven and outputs
// sampled on the falling edge of clk. Expected HI/LO come from a plain
// 64-bit arithmetic model.
module tb_muldiv_control;

  localparam int WIDTH = 32;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_NOP   = 6'b100000;

  // Clock / reset and DUT signals
  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [5:0]       Funct;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [0:0]       dbg_state;

  always #5 clk = ~clk;

  muldiv_control #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .Funct       (Funct),
    .a           (a),
    .b           (b),
    .flush       (flush),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .dbg_state_o (dbg_state)
  );

  // Scoreboard state
  int               total = 0;
  int               bad   = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] m_hi;
  logic [WIDTH-1:0] m_lo;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: MIPS HI/LO semantics from plain 64-bit arithmetic.
  function automatic void ref_op(input logic [5:0] f, input logic [31:0] av,
                                 input logic [31:0] bv,
                                 output logic [31:0] rh, output logic [31:0] rl);
    longint          sa, sb, p, q, r;
    longint unsigned ua, ub, up;
    logic [63:0]     w;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    ua = {32'd0, av};
    ub = {32'd0, bv};
    rh = '0;
    rl = '0;
    case (f)
      F_MULT: begin
        p = sa * sb;
        w = 64'(p);
        rh = w[63:32];
        rl = w[31:0];
      end
      F_MULTU: begin
        up = ua * ub;
        w = up;
        rh = w[63:32];
        rl = w[31:0];
      end
      F_DIV: begin
        if (bv == 32'd0) begin
          rl = 32'hFFFF_FFFF;
          rh = av;
        end else if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
          rl = 32'h8000_0000;
          rh = 32'd0;
        end else begin
          q = sa / sb;
          r = sa % sb;
          rl = 32'(q);
          rh = 32'(r);
        end
      end
      F_DIVU: begin
        if (bv == 32'd0) begin
          rl = 32'hFFFF_FFFF;
          rh = av;
        end else begin
          rl = 32'(ua / ub);
          rh = 32'(ua % ub);
        end
      end
      default: begin
        rh = m_hi;
        rl = m_lo;
      end
    endcase
  endfunction

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  // Driver: MTHI/MTLO. Called at a falling edge while the unit is idle.
  task automatic mt_write(input logic [5:0] f, input logic [31:0] v);
    start = 1'b1;
    Funct = f;
    a     = v;
    b     = $urandom;
    @(negedge clk);
    start = 1'b0;
    Funct = F_NOP;
    if (f == F_MTHI) m_hi = v;
    else             m_lo = v;
    check_eq("mt_hi", 64'(hi), 64'(m_hi));
    check_eq("mt_lo", 64'(lo), 64'(m_lo));
    check_eq("mt_no_done", 64'(done), 64'd0);
    check_eq("mt_no_busy", 64'(busy), 64'd0);
  endtask

  // Driver: MULT/MULTU/DIV/DIVU. Called at a falling edge while the unit is
  // idle or done is high. Returns at the falling edge where done is seen, so
  // a following call issues back-to-back.
  task automatic run_op(input logic [5:0] f, input logic [31:0] av,
                        input logic [31:0] bv, input bit check_pulse);
    logic [31:0] eh, el, xl, xh;
    int          busy_cnt;
    bit          seen;
    ref_op(f, av, bv, eh, el);
    exp_q.push_back(el);
    exp_q.push_back(eh);
    start = 1'b1;
    Funct = f;
    a     = av;
    b     = bv;
    @(negedge clk);
    start = 1'b0;
    Funct = F_NOP;
    a     = $urandom;
    b     = $urandom;
    busy_cnt = 0;
    seen     = 1'b0;
    for (int i = 0; i < WIDTH + 4; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
      @(negedge clk);
    end
    xl = exp_q.pop_front();
    xh = exp_q.pop_front();
    check_eq("done_seen", 64'(seen), 64'd1);
    check_eq("busy_cycles", 64'(busy_cnt), 64'(WIDTH));
    check_eq("res_lo", 64'(lo), 64'(xl));
    check_eq("res_hi", 64'(hi), 64'(xh));
    check_eq("busy_at_done", 64'(busy), 64'd0);
    m_hi = xh;
    m_lo = xl;
    if (check_pulse) begin
      @(negedge clk);
      check_eq("done_one_cycle", 64'(done), 64'd0);
      check_eq("hold_lo", 64'(lo), 64'(m_lo));
      check_eq("hold_hi", 64'(hi), 64'(m_hi));
    end
  endtask

  logic [5:0] ops[4] = '{F_MULT, F_MULTU, F_DIV, F_DIVU};

  initial begin
    bit saw_done;
    rst_n = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    Funct = F_NOP;
    a     = '0;
    b     = '0;
    m_hi  = '0;
    m_lo  = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_hi", 64'(hi), 64'd0);
    check_eq("rst_lo", 64'(lo), 64'd0);
    check_eq("rst_state", 64'(dbg_state), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed results, issued back-to-back
    run_op(F_MULT, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0);
    check_eq("mult_hi_const", 64'(hi), 64'hFFFF_FFFF);
    check_eq("mult_lo_const", 64'(lo), 64'hFFFF_FFFA);
    run_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check_eq("multu_hi_const", 64'(hi), 64'hFFFF_FFFE);
    check_eq("multu_lo_const", 64'(lo), 64'h0000_0001);
    run_op(F_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check_eq("div_lo_const", 64'(lo), 64'hFFFF_FFFD);
    check_eq("div_hi_const", 64'(hi), 64'hFFFF_FFFF);
    run_op(F_DIVU, 32'd7, 32'd0, 1'b0);
    check_eq("div0_lo_const", 64'(lo), 64'hFFFF_FFFF);
    check_eq("div0_hi_const", 64'(hi), 64'h0000_0007);
    run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    check_eq("ovf_lo_const", 64'(lo), 64'h8000_0000);
    check_eq("ovf_hi_const", 64'(hi), 64'h0);

    // Unlisted Funct is a no-op
    start = 1'b1;
    Funct = F_NOP;
    a     = 32'hA5A5_A5A5;
    @(negedge clk);
    start = 1'b0;
    check_eq("nop_busy", 64'(busy), 64'd0);
    check_eq("nop_hi", 64'(hi), 64'(m_hi));
    check_eq("nop_lo", 64'(lo), 64'(m_lo));

    // MTHI, then MULT flushed in RUN cycle 10 with an MTHI pending meanwhile
    mt_write(F_MTHI, 32'h1234_5678);
    start = 1'b1;
    Funct = F_MULT;
    a     = 32'h0000_1234;
    b     = 32'h0000_5678;
    @(negedge clk);
    check_eq("flush_busy_run", 64'(busy), 64'd1);
    Funct = F_MTHI;
    a     = 32'hDEAD_BEEF;
    repeat (9) @(negedge clk);
    check_eq("start_ignored_busy", 64'(hi), 64'h1234_5678);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    start = 1'b0;
    Funct = F_NOP;
    check_eq("flush_busy_low", 64'(busy), 64'd0);
    check_eq("flush_state", 64'(dbg_state), 64'd0);
    check_eq("flush_hi", 64'(hi), 64'h1234_5678);
    check_eq("flush_lo", 64'(lo), 64'(m_lo));
    saw_done = 1'b0;
    for (int i = 0; i < WIDTH + 2; i++) begin
      if (done) saw_done = 1'b1;
      @(negedge clk);
    end
    check_eq("flush_no_done", 64'(saw_done), 64'd0);

    // flush outranks start in IDLE
    start = 1'b1;
    flush = 1'b1;
    Funct = F_MTLO;
    a     = 32'hCAFE_F00D;
    @(negedge clk);
    check_eq("prio_mtlo", 64'(lo), 64'(m_lo));
    Funct = F_MULT;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    Funct = F_NOP;
    check_eq("prio_mult", 64'(busy), 64'd0);

    // Randomized operations with occasional MTHI/MTLO in between
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0)
        mt_write(($urandom_range(0, 1) == 0) ? F_MTHI : F_MTLO, 32'($urandom));
      run_op(ops[$urandom_range(0, 3)], rand_opnd(), rand_opnd(),
             ($urandom_range(0, 3) == 0));
    end

    // Reset in the middle of RUN
    start = 1'b1;
    Funct = F_DIV;
    a     = 32'($urandom);
    b     = 32'($urandom);
    @(negedge clk);
    start = 1'b0;
    Funct = F_NOP;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", 64'(busy), 64'd0);
    check_eq("midrst_done", 64'(done), 64'd0);
    check_eq("midrst_hi", 64'(hi), 64'd0);
    check_eq("midrst_lo", 64'(lo), 64'd0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    @(negedge clk);
    // Start presented in the first cycle after release is not accepted
    rst_n = 1'b1;
    start = 1'b1;
    Funct = F_MTHI;
    a     = 32'h55AA_55AA;
    @(negedge clk);
    start = 1'b0;
    Funct = F_NOP;
    check_eq("post_rst_ignored", 64'(hi), 64'd0);
    check_eq("post_rst_busy", 64'(busy), 64'd0);
    mt_write(F_MTLO, 32'h0F0F_0F0F);
    run_op(F_MULTU, 32'd6, 32'd7, 1'b1);

    check_eq("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
